stage2_n_type_sched: RTL and testbench

Sequencer that drives the three lane-select codes (m1..m3) of the stage-2 N-type message mux over a decoding iteration. It holds a small programmable schedule table; each entry gives one select code per lane plus a hold count. On start it replays the table for a programmed number of passes, honouring a downstream stall, then pulses done. It sits between the decoder top-level control and the stage-2 N-type mux.

---
 rtl/stage2_n_type_sched_pkg.sv | 41 ++++
 rtl/stage2_n_type_sched_table.sv | 29 ++
 rtl/stage2_n_type_sched.sv | 134 +++++++++++++
 tb/tb_stage2_n_type_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage2_n_type_sched_pkg.sv
// Shared constants, state encoding and table entry layout for the
// stage-2 N-type select sequencer.
package stage2_n_type_sched_pkg;

  localparam int CODE_W  = 3;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int HOLD_W  = 4;
  localparam int ITER_W  = 6;
  localparam int ENTRY_W = 3*CODE_W + HOLD_W;

  localparam logic [CODE_W-1:0] N_TYPE_L    = 3'd0;
  localparam logic [CODE_W-1:0] N_TYPE_M    = 3'd1;
  localparam logic [CODE_W-1:0] N_TYPE_N    = 3'd2;
  localparam logic [CODE_W-1:0] N_TYPE_R    = 3'd3;
  localparam logic [CODE_W-1:0] N_TYPE_S    = 3'd4;
  localparam logic [CODE_W-1:0] N_TYPE_IDLE = 3'b111;

  typedef enum logic [1:0] {
    NSCHED_IDLE = 2'd0,
    NSCHED_RUN  = 2'd1,
    NSCHED_DONE = 2'd2
  } nsched_state_e;

  typedef struct packed {
    logic [HOLD_W-1:0] hold;
    logic [CODE_W-1:0] m3;
    logic [CODE_W-1:0] m2;
    logic [CODE_W-1:0] m1;
  } sched_entry_t;

  function automatic sched_entry_t idle_entry();
    sched_entry_t e;
    e.hold = '0;
    e.m3   = N_TYPE_IDLE;
    e.m2   = N_TYPE_IDLE;
    e.m1   = N_TYPE_IDLE;
    return e;
  endfunction

endpackage

// File: rtl/stage2_n_type_sched_table.sv
// Schedule register file: one write port, one combinational read port,
// cleared to idle codes on reset.
module stage2_n_type_sched_table
  import stage2_n_type_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  sched_entry_t      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output sched_entry_t      rdata
);

  sched_entry_t mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= idle_entry();
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/stage2_n_type_sched.sv
// Replays the N-type lane-select schedule for a programmed number of
// passes, honouring downstream stall, then pulses done.
module stage2_n_type_sched
  import stage2_n_type_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [ENTRY_W-1:0] cfg_data,
  input  logic [ADDR_W-1:0]  cfg_last,
  input  logic [ITER_W-1:0]  iter_num,
  input  logic               start,
  input  logic               stall,
  output logic               busy,
  output logic               done,
  output logic               ctrl_valid,
  output logic [CODE_W-1:0]  N_type_control_m1,
  output logic [CODE_W-1:0]  N_type_control_m2,
  output logic [CODE_W-1:0]  N_type_control_m3,
  output logic [ADDR_W-1:0]  entry_idx,
  output logic [ITER_W-1:0]  iter_idx
);

  nsched_state_e     state_q;
  logic [ADDR_W-1:0] entry_q;
  logic [ADDR_W-1:0] last_q;
  logic [ITER_W-1:0] iter_q;
  logic [ITER_W-1:0] itn_q;
  logic [HOLD_W-1:0] hold_q;
  logic [CODE_W-1:0] m1_q, m2_q, m3_q;
  logic              valid_q, busy_q, done_q;

  logic              tbl_we;
  logic [ADDR_W-1:0] rd_addr;
  sched_entry_t      rd_e;
  logic              last_entry;

  assign tbl_we     = cfg_we && (state_q == NSCHED_IDLE);
  assign last_entry = (entry_q == last_q);

  // The read port always looks one entry ahead so the next codes can be
  // registered on the same edge the current entry expires.
  always_comb begin
    rd_addr = '0;
    if (state_q == NSCHED_RUN && !last_entry) begin
      rd_addr = entry_q + 1'b1;
    end
  end

  stage2_n_type_sched_table u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (tbl_we),
    .waddr (cfg_addr),
    .wdata (sched_entry_t'(cfg_data)),
    .raddr (rd_addr),
    .rdata (rd_e)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= NSCHED_IDLE;
      entry_q <= '0;
      last_q  <= '0;
      iter_q  <= '0;
      itn_q   <= '0;
      hold_q  <= '0;
      m1_q    <= N_TYPE_IDLE;
      m2_q    <= N_TYPE_IDLE;
      m3_q    <= N_TYPE_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        NSCHED_IDLE: begin
          if (start) begin
            last_q  <= cfg_last;
            itn_q   <= iter_num;
            entry_q <= '0;
            iter_q  <= '0;
            hold_q  <= rd_e.hold;
            m1_q    <= rd_e.m1;
            m2_q    <= rd_e.m2;
            m3_q    <= rd_e.m3;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= NSCHED_RUN;
          end
        end
        NSCHED_RUN: begin
          if (!stall) begin
            if (hold_q != '0) begin
              hold_q <= hold_q - 1'b1;
            end else if (last_entry && iter_q == itn_q) begin
              m1_q    <= N_TYPE_IDLE;
              m2_q    <= N_TYPE_IDLE;
              m3_q    <= N_TYPE_IDLE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= NSCHED_DONE;
            end else begin
              entry_q <= rd_addr;
              if (last_entry) begin
                iter_q <= iter_q + 1'b1;
              end
              hold_q <= rd_e.hold;
              m1_q   <= rd_e.m1;
              m2_q   <= rd_e.m2;
              m3_q   <= rd_e.m3;
            end
          end
        end
        NSCHED_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= NSCHED_IDLE;
        end
        default: state_q <= NSCHED_IDLE;
      endcase
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign ctrl_valid        = valid_q;
  assign N_type_control_m1 = m1_q;
  assign N_type_control_m2 = m2_q;
  assign N_type_control_m3 = m3_q;
  assign entry_idx         = entry_q;
  assign iter_idx          = iter_q;

endmodule

// File: tb/tb_stage2_n_type_sched.sv
// Directed-vector bench for the stage-2 N-type select sequencer.
module tb_stage2_n_type_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [12:0] cfg_data;
  logic [3:0]  cfg_last;
  logic [5:0]  iter_num;
  logic        start;
  logic        stall;
  logic        busy, done, ctrl_valid;
  logic [2:0]  m1, m2, m3;
  logic [3:0]  entry_idx;
  logic [5:0]  iter_idx;

  int checks = 0;
  int errors = 0;

  stage2_n_type_sched dut (
    .clk               (clk),
    .rst               (rst),
    .cfg_we            (cfg_we),
    .cfg_addr          (cfg_addr),
    .cfg_data          (cfg_data),
    .cfg_last          (cfg_last),
    .iter_num          (iter_num),
    .start             (start),
    .stall             (stall),
    .busy              (busy),
    .done              (done),
    .ctrl_valid        (ctrl_valid),
    .N_type_control_m1 (m1),
    .N_type_control_m2 (m2),
    .N_type_control_m3 (m3),
    .entry_idx         (entry_idx),
    .iter_idx          (iter_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] pack(input logic [3:0] h,
                                       input logic [2:0] c3,
                                       input logic [2:0] c2,
                                       input logic [2:0] c1);
    return {h, c3, c2, c1};
  endfunction

  task automatic wr(input logic [3:0] a, input logic [12:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  // Leaves the bench at the negedge of cycle t1.
  task automatic go(input logic [3:0] last, input logic [5:0] itn);
    cfg_last = last;
    iter_num = itn;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic load_basic();
    wr(4'd0, pack(4'd0, 3'd2, 3'd1, 3'd0));
    wr(4'd1, pack(4'd2, 3'd0, 3'd4, 3'd3));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, ctrl_valid} !== 3'b000 || {m3, m2, m1} !== 9'h1ff ||
        entry_idx !== 4'd0 || iter_idx !== 6'd0) begin
      errors++;
      $display("FAIL reset_state: b/d/v=%b%b%b codes=%h e=%0d i=%0d req 000/1ff/0/0",
               busy, done, ctrl_valid, {m3, m2, m1}, entry_idx, iter_idx);
    end
  endtask

  task automatic test_reset_midrun();
    bit hit = 0;
    for (int a = 0; a < 3; a++) wr(4'(a), pack(4'd1, 3'd1, 3'd2, 3'd3));
    go(4'd2, 6'd0);
    for (int t = 0; t < 20 && !hit; t++) begin
      if (entry_idx == 4'd2) hit = 1;
      else @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL midrun_reach: entry_idx=%0d req 2", entry_idx);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || ctrl_valid !== 1'b0 || {m3, m2, m1} !== 9'h1ff ||
        entry_idx !== 4'd0) begin
      errors++;
      $display("FAIL midrun_reset: b=%b v=%b codes=%h e=%0d req 0/0/1ff/0",
               busy, ctrl_valid, {m3, m2, m1}, entry_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    go(4'd0, 6'd0);
    checks++;
    if (ctrl_valid !== 1'b1 || entry_idx !== 4'd0 || {m3, m2, m1} !== 9'h1ff) begin
      errors++;
      $display("FAIL restart_after_reset: v=%b e=%0d codes=%h req 1/0/1ff",
               ctrl_valid, entry_idx, {m3, m2, m1});
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    load_basic();
    go(4'd1, 6'd0);
    checks++;
    if ({m3, m2, m1} !== {3'd2, 3'd1, 3'd0} || ctrl_valid !== 1'b1 ||
        busy !== 1'b1 || entry_idx !== 4'd0) begin
      errors++;
      $display("FAIL basic_t1: codes=%h v=%b b=%b e=%0d req %h/1/1/0",
               {m3, m2, m1}, ctrl_valid, busy, entry_idx, {3'd2, 3'd1, 3'd0});
    end
    for (int t = 2; t <= 4; t++) begin
      @(negedge clk);
      checks++;
      if ({m3, m2, m1} !== {3'd0, 3'd4, 3'd3} || entry_idx !== 4'd1 ||
          ctrl_valid !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL basic_t%0d: codes=%h e=%0d v=%b d=%b req %h/1/1/0",
                 t, {m3, m2, m1}, entry_idx, ctrl_valid, done, {3'd0, 3'd4, 3'd3});
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || ctrl_valid !== 1'b0 ||
        {m3, m2, m1} !== 9'h1ff) begin
      errors++;
      $display("FAIL basic_done: d=%b b=%b v=%b codes=%h req 1/1/0/1ff",
               done, busy, ctrl_valid, {m3, m2, m1});
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: b=%b d=%b req 0/0", busy, done);
    end
  endtask

  task automatic test_iterations();
    go(4'd1, 6'd2);
    for (int t = 1; t <= 14; t++) begin
      int ps = (t - 1) / 4;
      int ee = ((t - 1) % 4 == 0) ? 0 : 1;
      if (t <= 12) begin
        checks++;
        if (entry_idx !== 4'(ee) || iter_idx !== 6'(ps) || ctrl_valid !== 1'b1) begin
          errors++;
          $display("FAIL iter_t%0d: e=%0d i=%0d v=%b req %0d/%0d/1",
                   t, entry_idx, iter_idx, ctrl_valid, ee, ps);
        end
      end
      checks++;
      if (done !== (t == 13)) begin
        errors++;
        $display("FAIL iter_done_t%0d: done=%b req %b", t, done, t == 13);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    go(4'd1, 6'd0);
    @(negedge clk);
    stall = 1'b1;
    for (int t = 3; t <= 7; t++) begin
      @(negedge clk);
      if (t == 7) stall = 1'b0;
      checks++;
      if (entry_idx !== 4'd1 || {m3, m2, m1} !== {3'd0, 3'd4, 3'd3} ||
          ctrl_valid !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL stall_t%0d: e=%0d codes=%h v=%b d=%b req 1/%h/1/0",
                 t, entry_idx, {m3, m2, m1}, ctrl_valid, done, {3'd0, 3'd4, 3'd3});
      end
    end
    for (int t = 8; t <= 11; t++) begin
      @(negedge clk);
      checks++;
      if (done !== (t == 10)) begin
        errors++;
        $display("FAIL stall_done_t%0d: done=%b req %b", t, done, t == 10);
      end
    end
  endtask

  task automatic test_ignored_inputs();
    go(4'd1, 6'd0);
    start    = 1'b1;
    cfg_we   = 1'b1;
    cfg_addr = 4'd0;
    cfg_data = pack(4'd0, 3'd6, 3'd6, 3'd6);
    @(negedge clk);
    start  = 1'b0;
    cfg_we = 1'b0;
    for (int t = 3; t <= 6; t++) begin
      @(negedge clk);
      if (t == 4) begin
        checks++;
        if (entry_idx !== 4'd1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL ignore_no_restart: e=%0d b=%b req 1/1", entry_idx, busy);
        end
      end
      if (t == 5) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL ignore_done: done=%b req 1", done);
        end
      end
    end
    go(4'd1, 6'd0);
    checks++;
    if ({m3, m2, m1} !== {3'd2, 3'd1, 3'd0}) begin
      errors++;
      $display("FAIL ignore_readback: codes=%h req %h",
               {m3, m2, m1}, {3'd2, 3'd1, 3'd0});
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_passthrough();
    wr(4'd0, pack(4'd2, 3'b101, 3'b101, 3'b101));
    go(4'd0, 6'd0);
    for (int t = 1; t <= 4; t++) begin
      if (t <= 3) begin
        checks++;
        if ({m3, m2, m1} !== 9'b101101101 || ctrl_valid !== 1'b1) begin
          errors++;
          $display("FAIL pass_t%0d: codes=%b v=%b req 101101101/1",
                   t, {m3, m2, m1}, ctrl_valid);
        end
      end else begin
        checks++;
        if (done !== 1'b1 || {m3, m2, m1} !== 9'h1ff) begin
          errors++;
          $display("FAIL pass_done: d=%b codes=%h req 1/1ff", done, {m3, m2, m1});
        end
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    cfg_last = '0;
    iter_num = '0;
    start    = 1'b0;
    stall    = 1'b0;
    @(negedge clk);
    test_reset();
    test_reset_midrun();
    test_basic();
    test_iterations();
    test_stall();
    test_ignored_inputs();
    test_passthrough();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
